// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver character strobe/error bundle and FIFO read-side handshake.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_framing_error;
  logic       rx_parity_error;
  logic       rx_busy;
  logic [7:0] rd_data;
  logic       rd_framing_error;
  logic       rd_parity_error;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rx_data, rx_valid, rx_framing_error, rx_parity_error, rx_busy, rd_ready,
    input  rd_data, rd_framing_error, rd_parity_error, rd_valid
  );

  modport slave (
    input  rx_data, rx_valid, rx_framing_error, rx_parity_error, rx_busy, rd_ready,
    output rd_data, rd_framing_error, rd_parity_error, rd_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: error-tagged FWFT receive FIFO with overrun, threshold and character-timeout status.
// Define UART_RX_FIFO_BREAK_DETECT_EN to treat framing-error NUL characters as line breaks.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_BITS = 40,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          flush,
  uart_rx_fifo_if.slave bus,
  input  logic          osr_tick,
  input  logic [7:0]    osr_value,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  input  logic [AW:0]   rx_threshold,
  output logic          thresh_irq,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic          timeout_irq,
  output logic          break_detect
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_BITS);

  logic [9:0]    mem [DEPTH];
  logic [9:0]    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pend_fe;
  logic          pend_pe;
  logic          eff_fe;
  logic          eff_pe;
  logic          is_break;
  logic          accept;
  logic          push;
  logic          pop;
  logic          drop;
  logic          cnt_clr;
  logic [7:0]    tick_cnt;
  logic [7:0]    tick_max;
  logic [15:0]   bit_cnt;

  assign empty      = (count == '0);
  assign full       = (count == FULL_LVL);
  assign level      = count;
  assign thresh_irq = (rx_threshold != '0) && (count >= rx_threshold);

  // Head is forced to zero when empty so stale storage never shows on the read side.
  assign head                 = empty ? '0 : mem[rd_ptr];
  assign bus.rd_valid         = !empty;
  assign bus.rd_framing_error = head[9];
  assign bus.rd_parity_error  = head[8];
  assign bus.rd_data          = head[7:0];

  assign eff_fe = pend_fe | bus.rx_framing_error;
  assign eff_pe = pend_pe | bus.rx_parity_error;

`ifdef UART_RX_FIFO_BREAK_DETECT_EN
  assign is_break = eff_fe && (bus.rx_data == 8'h00);
`else
  assign is_break = 1'b0;
`endif

  assign accept   = bus.rx_valid && enable && !flush && !is_break;
  assign pop      = !empty && bus.rd_ready && !flush;
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign tick_max = (osr_value == '0) ? 8'd0 : osr_value - 8'd1;
  assign cnt_clr  = push || pop || flush || bus.rx_busy || empty || !enable;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {eff_fe, eff_pe, bus.rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pend_fe     <= 1'b0;
      pend_pe     <= 1'b0;
      overrun     <= 1'b0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      timeout_irq <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end

      // Error pulses may arrive ahead of their character; any strobe consumes them.
      if (flush || !enable || bus.rx_valid) begin
        pend_fe <= 1'b0;
        pend_pe <= 1'b0;
      end else begin
        if (bus.rx_framing_error) pend_fe <= 1'b1;
        if (bus.rx_parity_error)  pend_pe <= 1'b1;
      end

      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      if (cnt_clr) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (osr_tick) begin
        if (tick_cnt >= tick_max) begin
          tick_cnt <= '0;
          if (bit_cnt < TO_LIM) bit_cnt <= bit_cnt + 16'd1;
        end else begin
          tick_cnt <= tick_cnt + 8'd1;
        end
      end

      // Latched so a later rx_busy restart of the counter does not drop the interrupt.
      if (push || pop || flush)    timeout_irq <= 1'b0;
      else if (bit_cnt == TO_LIM)  timeout_irq <= 1'b1;
    end
  end

`ifdef UART_RX_FIFO_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst || flush)
      break_detect <= 1'b0;
    else if (bus.rx_valid && enable && is_break)
      break_detect <= 1'b1;
  end
`else
  assign break_detect = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It takes received characters from the receiver's data_out/data_valid/error pulses, tags each one with its framing and parity error status, and stores it in a first-word-fall-through FIFO for the register/bus side. It also provides fill-level status, a sticky overrun flag, a threshold interrupt, and a character-timeout interrupt timed in bit periods from the shared oversample tick.

Parameters:
DEPTH, 16, number of FIFO entries; power of 2, at least 2.
TIMEOUT_BITS, 40, idle bit periods (4 ten-bit characters) before timeout_irq asserts.
AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
enable  in  1  block enable; low = ignore receiver, hold timeout.
flush  in  1  one-cycle pulse; empties FIFO.
rx_data  in  8  received character from receiver.
rx_valid  in  1  one-cycle character strobe.
rx_framing_error  in  1  framing error pulse; may precede rx_valid.
rx_parity_error  in  1  parity error pulse; precedes rx_valid.
rx_busy  in  1  receiver mid-frame.
osr_tick  in  1  oversample tick.
osr_value  in  8  oversample ticks per bit; 0 is treated as 1.
rd_data  out  8  head entry data.
rd_framing_error  out  1  head entry framing tag.
rd_parity_error  out  1  head entry parity tag.
rd_valid  out  1  equals !empty.
rd_ready  in  1  pop when rd_valid && rd_ready.
level  out  AW+1  current entry count, 0..DEPTH.
empty  out  1  level == 0.
full  out  1  level == DEPTH.
rx_threshold  in  AW+1  interrupt threshold.
thresh_irq  out  1  (rx_threshold != 0) && (level >= rx_threshold).
overrun  out  1  sticky; set when a push is dropped.
overrun_clr  in  1  clears overrun.
timeout_irq  out  1  level-type character timeout.
break_detect  out  1  sticky; see Optional Feature.

Behaviour:
- Reset: pointers 0, level 0, empty 1, full 0, rd_valid 0, rd_data/tags 0, overrun 0, timeout_irq 0, thresh_irq 0, break_detect 0, pending error bits 0.
- Pending error capture: rx_framing_error and rx_parity_error pulses set pend_fe and pend_pe. A push stores {pend_fe | rx_framing_error, pend_pe | rx_parity_error, rx_data}. pend bits clear on rx_valid (whether stored or dropped), flush, or enable low.
- Push: rx_valid && enable && (!full || pop this cycle). The entry is written at wr_ptr and wr_ptr increments, wrapping mod DEPTH.
- Dropped push: rx_valid && enable && full && !pop. Data is discarded; overrun sets next cycle.
- Pop: rd_valid && rd_ready. rd_ptr increments, wrapping. rd_data/tags are combinational from the head entry, so rd_data is valid in the same cycle as rd_valid (zero latency).
- Simultaneous push and pop: both happen and level is unchanged, including when full. When empty, pop is impossible and only the push occurs.
- Push to empty: rd_valid rises the cycle after the rx_valid edge.
- Flush: the FIFO is emptied in one cycle. Flush wins over a coincident push or pop. Overrun is not cleared by flush.
- overrun_clr: if a new overrun occurs in the same cycle, set wins.
- enable low: pushes are ignored and the timeout counter is held at 0. Stored entries stay readable and pops still work.
- Timeout counter: tick_cnt (8b) and bit_cnt (16b).
  - Counts only when enable && !empty && !rx_busy && osr_tick.
  - tick_cnt counts 0..max(osr_value,1)-1; on wrap, bit_cnt increments and saturates at TIMEOUT_BITS.
  - Both counters clear on push, pop, flush, rx_busy high, or empty.
  - timeout_irq = (bit_cnt == TIMEOUT_BITS), registered. It stays asserted until a push, pop, or flush occurs.
- Reset mid-frame: everything returns to reset values. A later rx_valid is stored with no stale error tags.

Optional Feature:
Macro: UART_RX_FIFO_BREAK_DETECT_EN.
- Defined: a character whose effective framing tag is 1 and rx_data == 8'h00 is treated as a line break. It is not stored. break_detect sets (sticky, cleared by flush or reset), and the pending error bits clear.
- Undefined: break_detect is tied 0, and such characters are stored as normal entries tagged with a framing error.

Test Plan:
- Push 0x41, 0x42, 0x43 with rd_ready=0 -> level=3, rd_data=0x41; raise rd_ready for 3 cycles -> reads 0x41, 0x42, 0x43 in order, then empty=1.
- rx_parity_error pulse, then rx_valid with 0x55 20 cycles later -> entry {fe=0, pe=1, 0x55}; next char 0x56 has pe=0.
- Fill 16 entries, push 0x99 without pop -> overrun=1, level=16, 0x99 absent; push and pop in the same cycle when full -> level stays 16; overrun_clr -> overrun=0.
- rx_threshold=4, push 4 chars -> thresh_irq rises on the 4th push; pop 1 -> thresh_irq falls.
- osr_value=16, 1 entry, idle -> timeout_irq after 40×16=640 ticks; one rd pop clears it; rx_busy pulse at 600 ticks restarts the count.
- Framing-error 0x00 with macro defined -> break_detect=1, level unchanged; without macro -> level+1, entry fe=1.
